// File: rtl/eth_header_parser.sv
// Ingress FIFO read-side consumer: prefetches FIFO words into a 3-entry buffer,
// extracts the Ethernet header and streams the payload, dropping runt frames.
module eth_header_parser #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   fifo_occu,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic [47:0]           dst_mac,
    output logic [47:0]           src_mac,
    output logic [15:0]           ethertype,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [7:0]            payload_data,
    output logic                  payload_valid,
    output logic                  payload_last,
    input  logic                  payload_ready,
    output logic                  runt_error,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_HDR_OUT = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    localparam int EOF_BIT  = DATA_WIDTH - 1;
    localparam int BUF_SIZE = 3;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_SIZE];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            buf_count;
    logic                  inflight;
    logic                  rd_req;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  buf_nonempty;
    logic [3:0]            byte_idx;
    logic [3:0]            byte_idx_nxt;
    logic [111:0]          hdr_shift;
    logic                  hdr_load;
    logic                  hdr_clr;
    logic                  runt_set;
    logic                  count_inc;
    logic [ADDR_WIDTH:0]   inflight_ext;
    logic [2:0]            committed;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign head         = buf_mem[rd_ptr];
    assign buf_nonempty = (buf_count != 2'd0);
    assign push         = inflight;

    // A read is only issued when the FIFO holds a word beyond the one already
    // in flight and the buffer can absorb both.
    assign inflight_ext = {{ADDR_WIDTH{1'b0}}, inflight};
    assign committed    = {1'b0, buf_count} + {2'b00, inflight};
    assign rd_req       = (fifo_occu > inflight_ext) && (committed < 3'd3);
    assign fifo_read_enable = rd_req & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                buf_mem[i] <= '0;
            end
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            buf_count <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_req;
            if (push) begin
                buf_mem[wr_ptr] <= fifo_read_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        pop          = 1'b0;
        hdr_load     = 1'b0;
        hdr_clr      = 1'b0;
        runt_set     = 1'b0;
        count_inc    = 1'b0;
        case (state)
            S_HDR: begin
                if (buf_nonempty) begin
                    pop = 1'b1;
                    if (head[EOF_BIT]) begin
                        runt_set     = 1'b1;
                        hdr_clr      = 1'b1;
                        byte_idx_nxt = 4'd0;
                    end else begin
                        hdr_load = 1'b1;
                        if (byte_idx == 4'd13) begin
                            byte_idx_nxt = 4'd0;
                            state_nxt    = S_HDR_OUT;
                        end else begin
                            byte_idx_nxt = byte_idx + 4'd1;
                        end
                    end
                end
            end
            S_HDR_OUT: begin
                if (hdr_ready) begin
                    count_inc = 1'b1;
                    state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (buf_nonempty && payload_ready) begin
                    pop = 1'b1;
                    if (head[EOF_BIT]) begin
                        state_nxt    = S_HDR;
                        byte_idx_nxt = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt    = S_HDR;
                byte_idx_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_HDR;
            byte_idx    <= 4'd0;
            hdr_shift   <= '0;
            runt_error  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            runt_error <= runt_set;
            if (hdr_clr) begin
                hdr_shift <= '0;
            end else if (hdr_load) begin
                hdr_shift <= {hdr_shift[103:0], head[7:0]};
            end
            if (count_inc) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Header bytes enter at the bottom, so byte 0 ends up in the top octet.
    assign dst_mac   = hdr_shift[111:64];
    assign src_mac   = hdr_shift[63:16];
    assign ethertype = hdr_shift[15:0];
    assign hdr_valid = (state == S_HDR_OUT);

    assign payload_valid = (state == S_PAYLOAD) && buf_nonempty;
    assign payload_data  = payload_valid ? head[7:0] : 8'd0;
    assign payload_last  = payload_valid ? head[EOF_BIT] : 1'b0;

endmodule

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- Read-domain consumer of the switch ingress async FIFO.
- Drains 9-bit FIFO words into a 3-entry prefetch buffer. Bits [7:0] are the byte; bit 8 is the end-of-frame flag.
- Extracts the Ethernet header (destination MAC, source MAC, EtherType) for the forwarding logic, then streams the payload bytes on a valid/ready interface.
- Drops runt frames and reports them.

Parameters:
- DATA_WIDTH, 9, FIFO word width. Bit 8 is EOF; bits [7:0] are the byte. Only 9 is supported.
- ADDR_WIDTH, 4, FIFO address width. Sets the occupancy width to ADDR_WIDTH+1.

Ports:
- clk  in  1  clock; same clock as the FIFO read side.
- reset  in  1  asynchronous, active-low reset.
- fifo_occu  in  ADDR_WIDTH+1  FIFO read-side occupancy.
- fifo_read_enable  out  1  pop request to the FIFO.
- fifo_read_data  in  DATA_WIDTH  FIFO read data. Valid in the cycle after fifo_read_enable.
- dst_mac  out  48  destination MAC; frame byte 0 = bits [47:40].
- src_mac  out  48  source MAC; frame byte 6 = bits [47:40].
- ethertype  out  16  frame bytes 12..13, big-endian.
- hdr_valid  out  1  header fields valid; held until accepted.
- hdr_ready  in  1  header accepted when hdr_valid & hdr_ready.
- payload_data  out  8  payload byte.
- payload_valid  out  1  payload byte valid.
- payload_last  out  1  final byte of the frame.
- payload_ready  in  1  consumer ready.
- runt_error  out  1  one-cycle pulse when a frame is dropped.
- frame_count  out  16  count of accepted headers; wraps at 16'hFFFF to 0.

Behaviour:
Reset:
- reset low clears everything asynchronously: buffer, in-flight flag, FSM (to HDR, byte index 0), header registers, frame_count.
- All outputs are 0 while reset is low.
- Reset mid-frame discards the partial frame; there is no recovery of FIFO contents.

FIFO read and prefetch:
- At most one read in flight.
- fifo_read_enable = (fifo_occu > inflight) & (buf_count + inflight < 3), evaluated on current-cycle values.
- The read word is written to the buffer tail at the end of the cycle after the read.
- Reads run independently of FSM state; bytes of the next frame are never lost.
- Sustained rate: 1 byte/cycle when the FIFO is non-empty and the consumer is ready.
- Simultaneous push and pop in the same cycle leaves buf_count unchanged.

FSM HDR:
- Pops the buffer head every cycle the buffer is non-empty.
- Stores the byte at byte index 0..13 into the header registers.
- EOF on any header byte (index 0..13) is a runt: pulse runt_error, discard the header, reset the index to 0, stay in HDR, no hdr_valid.
- Index 13 popped without EOF -> HDR_OUT.

FSM HDR_OUT:
- hdr_valid = 1; no pops.
- Header registers are stable.
- On hdr_valid & hdr_ready: frame_count += 1 -> PAYLOAD.

FSM PAYLOAD:
- payload_valid = buf_count != 0.
- payload_data = head[7:0]; payload_last = head[8].
- Pop on payload_valid & payload_ready.
- Popping the EOF byte -> HDR, index 0.
- payload_valid is held with stable data while payload_ready is low.

Latency:
- First FIFO read in cycle 0, FIFO never empty, hdr_ready held 1: hdr_valid rises in cycle 16.
- The first payload byte is valid in cycle 17.

Test Plan:
- Basic frame: 20-byte frame 00..13 (EOF on 13h), all readies high -> dst_mac=000102030405, src_mac=060708090A0B, ethertype=0C0D; hdr_valid in cycle 16; payload 0E..13 on consecutive cycles, payload_last only on 13h; frame_count=1.
- Runt: 10-byte frame with EOF on byte 9 -> runt_error pulses once, hdr_valid never asserts, frame_count stays 0; a following 20-byte frame parses correctly.
- Back-to-back: two 15-byte frames loaded before start, hdr_ready held 0 for 20 cycles on frame 1 -> buf_count saturates at 3, no reads while full, no bytes lost; both headers and payload bytes (1 each, payload_last=1) correct; frame_count=2.
- Backpressure: payload_ready toggled 1/0 every cycle -> each byte held stable while not ready, no duplicates or drops, byte order preserved.
- FIFO starvation: fifo_occu alternates 0/1 mid-header -> fifo_read_enable never asserts while fifo_occu==0 or with a read in flight when fifo_occu==1; header still correct.
- Reset mid-payload: reset low during byte 3 of payload -> all outputs 0 immediately; after release, a fresh frame parses with frame_count=1.
